// File: rtl/seq_pkg.sv
// seq_pkg: shared constants for the instruction sequencer.
//   - FSM state encodings (plain 4-bit constants, legacy-compatible)
//   - opcode / op field values and the decoded instruction class
//   - regfile write-data select codes (VSEL_C / VSEL_IMM)
//   - instruction field bit positions
package seq_pkg;

    localparam int unsigned W_DATA = 16;
    localparam int unsigned W_REG  = 3;

    // FSM state encodings
    localparam logic [3:0] S_WAIT   = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_GET_A  = 4'd2;
    localparam logic [3:0] S_GET_B  = 4'd3;
    localparam logic [3:0] S_EXEC   = 4'd4;
    localparam logic [3:0] S_EXEC_S = 4'd5;
    localparam logic [3:0] S_WR_RD  = 4'd6;
    localparam logic [3:0] S_WR_IMM = 4'd7;
    localparam logic [3:0] S_TRAP   = 4'd8;

    // opcode = IR[15:13], op = IR[12:11]
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // regfile write-data select
    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    // instruction field positions
    localparam int unsigned F_OPC_HI = 15;
    localparam int unsigned F_OPC_LO = 13;
    localparam int unsigned F_OP_HI  = 12;
    localparam int unsigned F_OP_LO  = 11;
    localparam int unsigned F_RN_HI  = 10;
    localparam int unsigned F_RN_LO  = 8;
    localparam int unsigned F_RD_HI  = 7;
    localparam int unsigned F_RD_LO  = 5;
    localparam int unsigned F_SH_HI  = 4;
    localparam int unsigned F_SH_LO  = 3;
    localparam int unsigned F_RM_HI  = 2;
    localparam int unsigned F_RM_LO  = 0;
    localparam int unsigned F_IMM_HI = 7;

    // decoded instruction class; CLS_NOP covers every undefined opcode/op
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN
    } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational field decode of the instruction register.
// Ports:
//   ir      in  16  instruction register contents
//   rn/rd/rm out 3  register number fields
//   sh      out 2   shift field IR[4:3]
//   aluop   out 2   ALU op field IR[12:11]
//   sximm8  out 16  sign-extended IR[7:0]
//   cls     out     decoded instruction class (CLS_NOP when undefined)
module instr_decoder
    import seq_pkg::*;
(
    input  logic [W_DATA-1:0] ir,
    output logic [W_REG-1:0]  rn,
    output logic [W_REG-1:0]  rd,
    output logic [W_REG-1:0]  rm,
    output logic [1:0]        sh,
    output logic [1:0]        aluop,
    output logic [W_DATA-1:0] sximm8,
    output instr_class_t      cls
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode = ir[F_OPC_HI:F_OPC_LO];
    assign op     = ir[F_OP_HI:F_OP_LO];
    assign rn     = ir[F_RN_HI:F_RN_LO];
    assign rd     = ir[F_RD_HI:F_RD_LO];
    assign rm     = ir[F_RM_HI:F_RM_LO];
    assign sh     = ir[F_SH_HI:F_SH_LO];
    assign aluop  = op;
    assign sximm8 = {{8{ir[F_IMM_HI]}}, ir[F_IMM_HI:0]};

    always_comb begin
        cls = CLS_NOP;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
            else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction register + Moore control FSM driving the 8x16
// register file ports and datapath enables, one state per clock.
// Ports:
//   clk, reset_n (async active-low)
//   s        start executing the held instruction (sampled in WAIT only)
//   load     IR load enable (honoured in WAIT only)
//   in       16-bit instruction word
//   w        1 = idle in WAIT
//   readnum, writenum, write         regfile control
//   loada, loadb, loadc, loads       datapath register enables
//   asel, bsel, vsel                 operand / write-data selects
//   shift, aluop, sximm8             combinational IR fields
//   illegal  trap flag
// Configuration macro: ILLEGAL_TRAP_EN -- when defined, an undefined
// instruction parks the FSM in TRAP (illegal=1) until reset; otherwise it is a
// NOP and illegal is tied 0.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned W_DATA = 16,
    parameter int unsigned W_REG  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s,
    input  logic              load,
    input  logic [W_DATA-1:0] in,
    output logic              w,
    output logic [W_REG-1:0]  readnum,
    output logic [W_REG-1:0]  writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        shift,
    output logic [1:0]        aluop,
    output logic [W_DATA-1:0] sximm8,
    output logic              illegal
);

    logic [W_DATA-1:0] ir_q, ir_d;
    logic [3:0]        state_q, state_d;

    logic [W_REG-1:0]  rn, rd, rm;
    instr_class_t      cls;

    instr_decoder u_dec (
        .ir     (ir_q),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (shift),
        .aluop  (aluop),
        .sximm8 (sximm8),
        .cls    (cls)
    );

    // IR only updates while idle so an in-flight instruction is never disturbed.
    // With s&load on the same edge DECODE sees the freshly loaded word.
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && load) ir_d = in;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (s) state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_MOV_IMM:                  state_d = S_WR_IMM;
                    CLS_MOV_REG, CLS_MVN:         state_d = S_GET_B;
                    CLS_ADD, CLS_AND, CLS_CMP:    state_d = S_GET_A;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_WAIT;
`endif
                    end
                endcase
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = (cls == CLS_CMP) ? S_EXEC_S : S_EXEC;
            S_EXEC:   state_d = S_WR_RD;
            S_EXEC_S: state_d = S_WAIT;
            S_WR_RD:  state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q    <= '0;
            state_q <= S_WAIT;
        end else begin
            ir_q    <= ir_d;
            state_q <= state_d;
        end
    end

    // Moore output decode
    always_comb begin
        w        = (state_q == S_WAIT);
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;
        case (state_q)
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                loadc = 1'b1;
                asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
            end
            S_EXEC_S: loads = 1'b1;
            S_WR_RD: begin
                writenum = rd;
                write    = 1'b1;
                vsel     = VSEL_C;
            end
            S_WR_IMM: begin
                writenum = rn;
                write    = 1'b1;
                vsel     = VSEL_IMM;
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule
